mem_request_sequencer: RTL and testbench

Bus-initiator engine between the Controller FSM and memory_controller on the shared main bus. It turns one abstract request (fetch, read, write, ISZ, deferred address) into one or more read/write handshakes against the memory responder. It handles PDP-8 auto-index (0o010–0o017) and ISZ read-modify-write, and returns data or a skip flag to the controller. It also aborts hung accesses with a watchdog.

---
 rtl/mem_request_sequencer_pkg.sv | 36 +++
 rtl/mem_request_sequencer.sv | 170 +++++++++++++++++
 tb/tb_mem_request_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_request_sequencer_pkg.sv
// Shared CPU memory-sequencer types: request opcodes, sequencer states,
// the 12-bit word type and the PDP-8 auto-index window.
package mem_request_sequencer_pkg;

  typedef logic [11:0] word_t;

  typedef enum logic [2:0] {
    OP_FETCH = 3'd0,
    OP_READ  = 3'd1,
    OP_WRITE = 3'd2,
    OP_ISZ   = 3'd3,
    OP_DEFER = 3'd4
  } mem_op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_GAP  = 3'd3,
    S_RESP = 3'd4
  } mseq_state_t;

  localparam word_t AI_LO = 12'o0010;
  localparam word_t AI_HI = 12'o0017;

  // Inclusive auto-index window check.
  function automatic logic in_ai_window(input word_t a);
    return (a >= AI_LO) && (a <= AI_HI);
  endfunction

  // Ops that read a word, increment it and write it back.
  function automatic logic needs_rmw(input mem_op_t op, input word_t a);
    return (op == OP_ISZ) || ((op == OP_DEFER) && in_ai_window(a));
  endfunction

endpackage

// File: rtl/mem_request_sequencer.sv
// Bus-initiator engine: turns one controller request into one or two
// read/write handshakes with the memory responder, with an inline
// watchdog that aborts hung accesses.
module mem_request_sequencer
  import mem_request_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic    clock,
  input  logic    resetN,
  // controller side
  input  logic    req_valid,
  input  mem_op_t req_op,
  input  word_t   req_addr,
  input  word_t   req_wdata,
  output logic    req_ready,
  output logic    rsp_valid,
  output word_t   rsp_data,
  output logic    rsp_skip,
  output logic    rsp_err,
  // memory side
  output word_t   address,
  output word_t   write_data,
  output logic    write_enable,
  output logic    read_enable,
  output logic    read_type,
  input  logic    mem_finished,
  input  word_t   mem_rdata
);

  localparam int unsigned WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  mseq_state_t     state_q, state_d;
  mem_op_t         op_q, op_d;
  word_t           addr_q, addr_d;
  word_t           wdata_q, wdata_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            pend_wr_q, pend_wr_d;
  logic            abort_q, abort_d;
  word_t           rsp_data_q, rsp_data_d;
  logic            rsp_skip_q, rsp_skip_d;
  logic            rsp_err_q, rsp_err_d;

  // State and datapath registers; reset drops the enables at once.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q    <= S_IDLE;
      op_q       <= OP_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
      wd_cnt_q   <= '0;
      pend_wr_q  <= 1'b0;
      abort_q    <= 1'b0;
      rsp_data_q <= '0;
      rsp_skip_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wd_cnt_q   <= wd_cnt_d;
      pend_wr_q  <= pend_wr_d;
      abort_q    <= abort_d;
      rsp_data_q <= rsp_data_d;
      rsp_skip_q <= rsp_skip_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Next-state, watchdog and response capture.
  // wdata_q doubles as the write-back value for read-modify-write ops, so the
  // WR completion always reports wdata_q regardless of op.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wd_cnt_d   = wd_cnt_q;
    pend_wr_d  = pend_wr_q;
    abort_d    = abort_q;
    rsp_data_d = rsp_data_q;
    rsp_skip_d = rsp_skip_q;
    rsp_err_d  = rsp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d      = req_op;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          wd_cnt_d  = '0;
          pend_wr_d = 1'b0;
          abort_d   = 1'b0;
          state_d   = (req_op == OP_WRITE) ? S_WR : S_RD;
        end
      end

      S_RD: begin
        if (mem_finished) begin
          if (needs_rmw(op_q, addr_q)) begin
            wdata_d   = mem_rdata + 12'd1;
            pend_wr_d = 1'b1;
            state_d   = S_GAP;
          end else begin
            rsp_data_d = mem_rdata;
            rsp_skip_d = 1'b0;
            rsp_err_d  = 1'b0;
            state_d    = S_RESP;
          end
        end else if (wd_cnt_q == WD_LAST) begin
          abort_d   = 1'b1;
          pend_wr_d = 1'b0;
          state_d   = S_GAP;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end

      S_WR: begin
        if (mem_finished) begin
          rsp_data_d = wdata_q;
          rsp_skip_d = (op_q == OP_ISZ) && (wdata_q == '0);
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (wd_cnt_q == WD_LAST) begin
          abort_d   = 1'b1;
          pend_wr_d = 1'b0;
          state_d   = S_GAP;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end

      S_GAP: begin
        wd_cnt_d = '0;
        if (pend_wr_q) begin
          pend_wr_d = 1'b0;
          state_d   = S_WR;
        end else begin
          rsp_data_d = '0;
          rsp_skip_d = 1'b0;
          rsp_err_d  = abort_q;
          state_d    = S_RESP;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready    = (state_q == S_IDLE);
  assign rsp_valid    = (state_q == S_RESP);
  assign rsp_data     = rsp_data_q;
  assign rsp_skip     = rsp_skip_q;
  assign rsp_err      = rsp_err_q;
  assign address      = addr_q;
  assign write_data   = wdata_q;
  assign read_enable  = (state_q == S_RD);
  assign write_enable = (state_q == S_WR);
  assign read_type    = (state_q == S_RD) && (op_q == OP_FETCH);

endmodule

// File: tb/tb_mem_request_sequencer.sv
// Self-checking bench: memory responder with per-access latency, an
// op-level expectation model and a per-cycle output checker.
module tb_mem_request_sequencer;
  import mem_request_sequencer_pkg::*;

  localparam int TO = 8;

  logic    clock = 1'b0;
  logic    resetN;
  logic    req_valid;
  mem_op_t req_op;
  word_t   req_addr, req_wdata;
  logic    req_ready, rsp_valid, rsp_skip, rsp_err;
  word_t   rsp_data, address, write_data, mem_rdata;
  logic    write_enable, read_enable, read_type, mem_finished;

  always #5 clock = ~clock;

  mem_request_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .resetN(resetN),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_skip(rsp_skip),
    .rsp_err(rsp_err),
    .address(address), .write_data(write_data), .write_enable(write_enable),
    .read_enable(read_enable), .read_type(read_type),
    .mem_finished(mem_finished), .mem_rdata(mem_rdata)
  );

  typedef struct {
    word_t d;
    logic  s;
    logic  e;
  } exp_t;

  int      errors = 0;
  int      checks = 0;
  int      cyc = 0;
  word_t   mem [0:4095];
  int      rd_lat = 0;
  int      wr_lat = 0;
  int      en_cnt = 0;
  int      last_en_len = 0;
  int      wr_commits = 0;
  mem_op_t cur_op = OP_READ;
  exp_t    exp_q[$];
  word_t   last_rsp = '0;
  logic    prev_re = 1'b0, prev_we = 1'b0;
  word_t   prev_addr = '0, prev_wd = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0o%0o expected 0o%0o", name, act, exp);
    end
  endtask

  // Memory responder: finishes an access on its (lat+1)-th enabled cycle.
  initial begin
    int lat;
    mem_finished = 1'b0;
    mem_rdata    = '0;
    forever begin
      @(negedge clock);
      if (resetN && (read_enable || write_enable)) begin
        en_cnt++;
        lat = read_enable ? rd_lat : wr_lat;
        if (lat >= 0 && en_cnt == lat + 1) begin
          mem_finished = 1'b1;
          if (read_enable) mem_rdata = mem[address];
          else begin
            mem[address] = write_data;
            wr_commits++;
          end
        end else begin
          mem_finished = 1'b0;
        end
      end else begin
        if (en_cnt != 0) last_en_len = en_cnt;
        en_cnt       = 0;
        mem_finished = 1'b0;
      end
    end
  end

  // Per-cycle output checker against the expectation queue.
  always @(negedge clock) begin
    if (!resetN) begin
      last_rsp = '0;
      prev_re  = 1'b0;
      prev_we  = 1'b0;
    end else begin
      chk("enable_exclusive", 32'(read_enable && write_enable), 0);
      chk("read_type", 32'(read_type), 32'(read_enable && (cur_op == OP_FETCH)));
      if ((read_enable && prev_re) || (write_enable && prev_we)) begin
        chk("address_stable", 32'(address), 32'(prev_addr));
        chk("write_data_stable", 32'(write_data), 32'(prev_wd));
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(e.d));
          chk("rsp_skip", 32'(rsp_skip), 32'(e.s));
          chk("rsp_err", 32'(rsp_err), 32'(e.e));
          last_rsp = e.d;
        end
      end else begin
        chk("rsp_data_hold", 32'(rsp_data), 32'(last_rsp));
      end
      prev_re   = read_enable;
      prev_we   = write_enable;
      prev_addr = address;
      prev_wd   = write_data;
    end
  end

  // Issue one request; expectations derived from the op rules and memory contents.
  task automatic do_req(input mem_op_t op, input word_t a, input word_t w,
                        input int rl, input int wl, output word_t got);
    word_t old, d;
    logic  skip, err, wr;
    int    nacc, first_lat, exp_lat, acc, wc0, k;
    bit    seen;
    old  = mem[a];
    skip = 1'b0;
    err  = 1'b0;
    wr   = 1'b0;
    case (op)
      OP_WRITE: begin nacc = 1; d = w; wr = 1'b1; end
      OP_ISZ:   begin nacc = 2; d = old + 12'd1; skip = (d == 0); wr = 1'b1; end
      OP_DEFER: begin
        if (a >= 12'o10 && a <= 12'o17) begin nacc = 2; d = old + 12'd1; wr = 1'b1; end
        else begin nacc = 1; d = old; end
      end
      default:  begin nacc = 1; d = old; end
    endcase
    first_lat = (op == OP_WRITE) ? wl : rl;
    if (first_lat < 0 || first_lat >= TO) begin
      err = 1'b1; exp_lat = TO + 1;
    end else if (nacc == 2 && (wl < 0 || wl >= TO)) begin
      err = 1'b1; exp_lat = (rl + 1) + 1 + TO + 1;
    end else if (nacc == 2) begin
      exp_lat = (rl + 1) + 1 + (wl + 1);
    end else begin
      exp_lat = first_lat + 1;
    end
    if (err) begin d = '0; skip = 1'b0; wr = 1'b0; end
    rd_lat = rl;
    wr_lat = wl;
    wc0    = wr_commits;
    exp_q.push_back('{d: d, s: skip, e: err});

    @(negedge clock);
    chk("req_ready_idle", 32'(req_ready), 1);
    cur_op    = op;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = w;
    @(negedge clock);
    acc       = cyc;
    req_valid = 1'b0;
    seen      = 1'b0;
    for (k = 0; k < 200; k++) begin
      chk("req_ready_busy", 32'(req_ready), 0);
      if (rsp_valid) begin seen = 1'b1; break; end
      @(negedge clock);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got no rsp_valid expected one within 200 cycles");
    end else begin
      chk("latency", 32'(cyc - acc + 1), 32'(exp_lat + 1));
    end
    got = rsp_data;
    @(negedge clock);
    chk("req_ready_after", 32'(req_ready), 1);
    if (wr) chk("mem_writeback", 32'(mem[a]), 32'(d));
    else    chk("mem_unchanged", 32'(mem[a]), 32'(old));
    chk("write_count", 32'(wr_commits - wc0), 32'(wr ? 1 : 0));
  endtask

  initial begin
    word_t g;
    int    wc0;
    bit    seen;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    resetN    = 1'b0;
    req_valid = 1'b0;
    req_op    = OP_READ;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    chk("reset_req_ready", 32'(req_ready), 1);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_enables", 32'({read_enable, write_enable, read_type}), 0);
    chk("reset_address", 32'(address), 0);
    chk("reset_rsp_data", 32'(rsp_data), 0);

    // READ with a slow responder
    mem[12'o0200] = 12'o1234;
    do_req(OP_READ, 12'o0200, '0, 3, 0, g);
    chk("read_value", 32'(g), 32'(12'o1234));
    chk("read_en_len", 32'(last_en_len), 4);

    // ISZ wrapping to zero -> skip
    mem[12'o0300] = 12'o7777;
    do_req(OP_ISZ, 12'o0300, '0, 0, 0, g);
    chk("isz_wrap_value", 32'(g), 0);
    chk("isz_wrap_mem", 32'(mem[12'o0300]), 0);
    mem[12'o0301] = 12'o0005;
    do_req(OP_ISZ, 12'o0301, '0, 1, 2, g);
    chk("isz_value", 32'(g), 32'(12'o0006));

    // Deferred addressing in and out of the auto-index window
    mem[12'o0012] = 12'o0477;
    do_req(OP_DEFER, 12'o0012, '0, 0, 0, g);
    chk("defer_ai_value", 32'(g), 32'(12'o0500));
    chk("defer_ai_mem", 32'(mem[12'o0012]), 32'(12'o0500));
    mem[12'o0020] = 12'o0477;
    do_req(OP_DEFER, 12'o0020, '0, 0, 0, g);
    chk("defer_plain_value", 32'(g), 32'(12'o0477));
    mem[12'o0010] = 12'o0100;
    do_req(OP_DEFER, 12'o0010, '0, 0, 0, g);
    mem[12'o0017] = 12'o7777;
    do_req(OP_DEFER, 12'o0017, '0, 0, 1, g);
    chk("defer_ai_wrap", 32'(g), 0);
    mem[12'o0007] = 12'o0321;
    do_req(OP_DEFER, 12'o0007, '0, 0, 0, g);

    // FETCH minimum latency and WRITE
    mem[12'o0100] = 12'o7402;
    do_req(OP_FETCH, 12'o0100, '0, 0, 0, g);
    chk("fetch_value", 32'(g), 32'(12'o7402));
    do_req(OP_WRITE, 12'o0400, 12'o1111, 0, 2, g);
    chk("write_value", 32'(g), 32'(12'o1111));

    // Watchdog: never finish, finish on expiry cycle, finish one too late
    do_req(OP_READ, 12'o0200, '0, -1, 0, g);
    chk("timeout_en_len", 32'(last_en_len), TO);
    do_req(OP_READ, 12'o0200, '0, TO - 1, 0, g);
    chk("expiry_finish_value", 32'(g), 32'(12'o1234));
    do_req(OP_READ, 12'o0200, '0, TO, 0, g);
    do_req(OP_ISZ, 12'o0301, '0, -1, 0, g);
    do_req(OP_ISZ, 12'o0301, '0, 0, -1, g);
    do_req(OP_WRITE, 12'o0401, 12'o2222, -1, -1, g);

    // Reset during the write-back of an ISZ
    mem[12'o0302] = 12'o0005;
    rd_lat    = 0;
    wr_lat    = -1;
    wc0       = wr_commits;
    cur_op    = OP_ISZ;
    @(negedge clock);
    req_valid = 1'b1;
    req_op    = OP_ISZ;
    req_addr  = 12'o0302;
    @(negedge clock);
    req_valid = 1'b0;
    seen      = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (write_enable) begin seen = 1'b1; break; end
      @(negedge clock);
    end
    chk("reset_test_wr_reached", 32'(seen), 1);
    @(negedge clock);
    #2 resetN = 1'b0;
    #1;
    chk("rst_write_enable", 32'(write_enable), 0);
    chk("rst_read_enable", 32'(read_enable), 0);
    chk("rst_outputs", 32'({rsp_valid, rsp_skip, rsp_err, read_type}), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_address", 32'(address), 0);
    chk("rst_write_data", 32'(write_data), 0);
    @(negedge clock);
    resetN = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("rst_no_rsp", 32'({rsp_valid, write_enable, read_enable}), 0);
    end
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_no_replay_mem", 32'(mem[12'o0302]), 32'(12'o0005));
    chk("rst_no_replay_count", 32'(wr_commits - wc0), 0);

    // Normal operation after reset
    do_req(OP_READ, 12'o0302, '0, 0, 0, g);
    chk("post_reset_read", 32'(g), 32'(12'o0005));

    repeat (2) @(negedge clock);
    chk("exp_queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish before 200000");
    $fatal(1, "bench time limit");
  end

endmodule
